// File: rtl/pkt_queue.sv
// Parametrised valid/ready packet FIFO with flush, occupancy and peak-occupancy reporting.
// Optional zero-cycle empty-queue bypass is enabled by defining PKT_QUEUE_BYPASS_EN.
module pkt_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    max_count,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    max_q, max_d;
    logic             push, pop, push_mem, pop_mem;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

`ifdef PKT_QUEUE_BYPASS_EN
    logic bypass;
    // Bypass only exists on an empty queue, and a flush kills it outright.
    assign bypass    = empty && in_valid && !flush;
    assign out_valid = !empty || bypass;
    assign out_data  = bypass ? in_data : mem[rd_ptr_q];
    assign push_mem  = push && !(bypass && out_ready);
    assign pop_mem   = pop && !empty;
`else
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr_q];
    assign push_mem  = push;
    assign pop_mem   = pop;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_mem) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_mem)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_mem, pop_mem})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        // count never exceeds DEPTH, so the peak saturates there on its own.
        max_d = (count_d > max_q) ? count_d : max_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            max_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            max_q    <= max_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_mem && !flush) mem[wr_ptr_q] <= in_data;
    end

    assign count     = count_q;
    assign max_count = max_q;

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst) !(push_mem && full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst) !(pop_mem && empty));
    a_ptr_count: assert property (@(posedge clk) disable iff (!rst)
        (count_q <= CW'(DEPTH)) && (AW'(count_q) == AW'(wr_ptr_q - rd_ptr_q)));
`endif

endmodule

// File: tb/tb_pkt_queue.sv
// Scoreboard bench for pkt_queue: handshakes are recorded at the falling edge and
// every popped packet is compared against the front of a reference queue.
module tb_pkt_queue;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready, out_valid, full, empty;
    logic [W-1:0]  out_data;
    logic [CW-1:0] count, max_count;

    int           tests_run = 0;
    int           failed = 0;
    logic [W-1:0] sb[$];
    int           mx = 0;
    bit           popped;
    logic [W-1:0] got, want;

    pkt_queue #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .max_count(max_count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    // One clock cycle: record the handshakes seen mid-cycle, then step past the edge.
    task automatic xfer();
        @(negedge clk);
        popped = 1'b0;
        got    = '0;
        want   = '0;
        if (flush) begin
            sb.delete();
        end else begin
            if (in_valid && in_ready) sb.push_back(in_data);
            if (out_valid && out_ready) begin
                popped = 1'b1;
                got    = out_data;
                want   = (sb.size() > 0) ? sb.pop_front() : 'x;
                $display("[TB] pop data=%h expected=%h", got, want);
            end
        end
        @(posedge clk);
        #1;
        if (sb.size() > mx) mx = sb.size();
    endtask

    task automatic drain_and_check(input string tag, input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            xfer();
            tests_run++;
            if (!popped || got !== want) begin
                failed++;
                $display("FAIL %s_pop%0d: got %h (popped=%0b) want %h", tag, i, got, popped, want);
            end
        end
        out_ready = 1'b0;
        tests_run++;
        if (empty !== 1'b1) begin failed++; $display("FAIL %s_empty: got %b want 1", tag, empty); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({count, max_count, empty, full, out_valid, in_ready} !== {CW'(0), CW'(0), 4'b1001}) begin
            failed++;
            $display("FAIL reset_state: got cnt=%0d max=%0d e=%b f=%b ov=%b ir=%b want 0 0 1 0 0 1",
                     count, max_count, empty, full, out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        mx = 0;
    endtask

    task automatic test_fill_drain();
        logic [W-1:0] vals [4];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = vals[i];
            xfer();
        end
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (count !== CW'(4)) begin failed++; $display("FAIL fill_count: got %0d want 4", count); end
        tests_run++;
        if (full !== 1'b1 || in_ready !== 1'b0) begin
            failed++; $display("FAIL fill_full: got full=%b in_ready=%b want 1 0", full, in_ready);
        end
        tests_run++;
        if (max_count !== CW'(4)) begin failed++; $display("FAIL fill_max: got %0d want 4", max_count); end
        drain_and_check("fill_drain", 4);
    endtask

    task automatic test_wrap();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hA0 + i;
            xfer();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hB0 + i;
            xfer();
            tests_run++;
            if (!popped || got !== want) begin
                failed++; $display("FAIL wrap_pop%0d: got %h want %h", i, got, want);
            end
            tests_run++;
            if (count !== CW'(3)) begin failed++; $display("FAIL wrap_count%0d: got %0d want 3", i, count); end
        end
        drain_and_check("wrap_drain", 3);
    endtask

    task automatic test_full_pushpop();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hC0 + i;
            xfer();
        end
        in_valid  = 1'b1;
        in_data   = 32'h99;
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin failed++; $display("FAIL fullpp_in_ready: got %b want 0", in_ready); end
        xfer();
        tests_run++;
        if (!popped || got !== want) begin failed++; $display("FAIL fullpp_pop: got %h want %h", got, want); end
        tests_run++;
        if (count !== CW'(3)) begin failed++; $display("FAIL fullpp_count: got %0d want 3", count); end
        tests_run++;
        if (in_ready !== 1'b1) begin failed++; $display("FAIL fullpp_ready_after: got %b want 1", in_ready); end
        drain_and_check("fullpp_drain", 3);
    endtask

    task automatic test_flush();
        int prior_max;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hD0 + i;
            xfer();
        end
        prior_max = mx;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hEE;
        xfer();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (count !== CW'(0) || empty !== 1'b1 || out_valid !== 1'b0) begin
            failed++; $display("FAIL flush_state: got cnt=%0d e=%b ov=%b want 0 1 0", count, empty, out_valid);
        end
        tests_run++;
        if (max_count !== CW'(prior_max)) begin
            failed++; $display("FAIL flush_max: got %0d want %0d", max_count, prior_max);
        end
        in_valid = 1'b1;
        in_data  = 32'h55;
        xfer();
        drain_and_check("flush_after", 1);
    endtask

    task automatic test_bypass();
        in_valid  = 1'b1;
        in_data   = 32'hAB;
        out_ready = 1'b1;
        #1;
`ifdef PKT_QUEUE_BYPASS_EN
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'hAB) begin
            failed++; $display("FAIL bypass_same_cycle: got ov=%b data=%h want 1 ab", out_valid, out_data);
        end
        xfer();
        in_valid = 1'b0;
        tests_run++;
        if (!popped || got !== want) begin failed++; $display("FAIL bypass_pop: got %h want %h", got, want); end
        tests_run++;
        if (count !== CW'(0)) begin failed++; $display("FAIL bypass_count: got %0d want 0", count); end
`else
        tests_run++;
        if (out_valid !== 1'b0) begin failed++; $display("FAIL nobypass_ov: got %b want 0", out_valid); end
        xfer();
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'hAB) begin
            failed++; $display("FAIL nobypass_next: got ov=%b data=%h want 1 ab", out_valid, out_data);
        end
        drain_and_check("nobypass", 1);
`endif
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic exp_ov;
        for (int i = 0; i < 150; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 19) == 0);
            #1;
            exp_ov = (sb.size() != 0);
`ifdef PKT_QUEUE_BYPASS_EN
            if (sb.size() == 0 && in_valid && !flush) exp_ov = 1'b1;
`endif
            tests_run++;
            if (count !== CW'(sb.size()) || full !== (sb.size() == D) || empty !== (sb.size() == 0)
                || in_ready !== (sb.size() != D) || out_valid !== exp_ov || max_count !== CW'(mx)) begin
                failed++;
                $display("FAIL rand_state%0d: got cnt=%0d f=%b e=%b ir=%b ov=%b max=%0d want cnt=%0d ov=%b max=%0d",
                         i, count, full, empty, in_ready, out_valid, max_count, sb.size(), exp_ov, mx);
            end
            xfer();
            if (popped) begin
                tests_run++;
                if (got !== want) begin failed++; $display("FAIL rand_pop%0d: got %h want %h", i, got, want); end
            end
        end
        flush = 1'b0;
        drain_and_check("rand_drain", sb.size());
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hF0 + i;
            xfer();
        end
        in_valid = 1'b0;
        tests_run++;
        if (count !== CW'(3)) begin failed++; $display("FAIL areset_pre_count: got %0d want 3", count); end
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({count, max_count, empty, full, out_valid, in_ready} !== {CW'(0), CW'(0), 4'b1001}) begin
            failed++;
            $display("FAIL areset_state: got cnt=%0d max=%0d e=%b f=%b ov=%b ir=%b want 0 0 1 0 0 1",
                     count, max_count, empty, full, out_valid, in_ready);
        end
        sb.delete();
        mx = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_pushpop();
        test_flush();
        test_bypass();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule

// File: doc/pkt_queue.md
Name: pkt_queue

Overview:
- Parametrised FIFO for pipeline packets (default payload is one full rv32i_packet::rv32i_packet_t).
- Successor to the single-entry stage buffers: configurable width and depth, valid/ready handshake on both sides, pipeline flush, occupancy and peak-occupancy reporting.
- Sits between IF and ID, or in front of EX, to decouple stalls.

Parameters:
- WIDTH, $bits(rv32i_packet::rv32i_packet_t), payload width in bits.
- DEPTH, 4, number of entries; power of two, >= 2.
- CW, $clog2(DEPTH+1), width of occupancy outputs (derived, do not override).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- flush  input  1  synchronous discard of all entries
- in_valid  input  1  producer has a packet
- in_ready  output  1  queue can accept a packet
- in_data  input  WIDTH  packet from producer
- out_valid  output  1  head packet is valid
- out_ready  input  1  consumer accepts head
- out_data  output  WIDTH  head packet
- count  output  CW  current occupancy
- max_count  output  CW  peak occupancy since reset
- full  output  1  count == DEPTH
- empty  output  1  count == 0

Behaviour:
- Reset (rst low, asynchronous):
  - wr_ptr, rd_ptr, count and max_count go to 0; empty=1, full=0, out_valid=0, in_ready=1.
  - Storage array is not reset.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push: in_valid && in_ready. Writes mem[wr_ptr] and increments wr_ptr at the clock edge.
- Pop: out_valid && out_ready. Increments rd_ptr at the clock edge.
- in_ready = !full:
  - Depends only on state, with no combinational path from out_ready.
  - When full, a push is refused even if a pop happens in the same cycle.
- out_valid = !empty; out_data = mem[rd_ptr].
  - out_data is don't-care while out_valid=0, except in bypass mode (see Optional Feature).
- Simultaneous push and pop (non-empty, non-full): both pointers advance and count is unchanged.
- Count update: +1 on push only, -1 on pop only, unchanged otherwise.
- Latency: a packet pushed at edge N is visible on out_data/out_valid after edge N (one-cycle fall-through) when the queue was empty.
- Flush has highest priority:
  - At the edge where flush=1, pointers and count go to 0.
  - Any push or pop in that cycle is discarded.
  - The handshake signals still show their normal combinational values during that cycle; the bench must not count those transfers.
  - max_count is not affected by flush.
- max_count updates at each edge to max(max_count, next count). It saturates at DEPTH.
- Ordering is strict FIFO. There is no reordering and no partial flush.
- Assertions (simulation only):
  - No push when full.
  - No pop when empty.
  - count == wr_ptr - rd_ptr (mod DEPTH), with full distinguished by count.

Optional Feature:
- Macro: PKT_QUEUE_BYPASS_EN.
- Defined:
  - When empty && in_valid, then out_valid=1 and out_data=in_data combinationally.
  - If out_ready is also high, the packet passes through in zero cycles. Neither pointer moves, count stays 0, and max_count is unchanged.
  - If out_ready is low, the packet is written normally.
  - A flush in the same cycle suppresses the bypass transfer: out_valid is forced to 0 while flush=1.
- Undefined:
  - out_valid = !empty strictly; minimum latency is one cycle.

Test Plan:
- Reset with DEPTH=4, then push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with out_ready=0 -> count=4, full=1, in_ready=0, max_count=4. Release out_ready -> pops 0x11, 0x22, 0x33, 0x44 in order, then empty=1.
- Fill with 3 entries, then hold in_valid and out_ready high for 10 cycles with incrementing data -> count stays 3, output order is preserved across pointer wrap, no drops.
- Full queue, push and pop in the same cycle -> push refused (in_ready=0), count goes 4 to 3, next cycle in_ready=1.
- Fill with 2 entries, assert flush together with in_valid -> next cycle count=0, empty=1, flushed and in-flight data never appear on out_data, max_count keeps its prior value.
- Assert rst low mid-stream (count=3) between clock edges -> outputs go immediately to reset values without waiting for a clock edge, max_count=0.
- With PKT_QUEUE_BYPASS_EN, empty queue, in_valid=1, in_data=0xAB, out_ready=1 -> out_valid=1 and out_data=0xAB in the same cycle, count remains 0. Without the macro -> out_valid=0 that cycle, 0xAB appears one cycle later.
